// File: rtl/rob_ss.sv
// rob_ss: reorder buffer with multi-wide dispatch/retire, multi-port completion
// and branch rollback. Defining ROB_SS_DEBUG_EN adds dbg_head, dbg_tail,
// dbg_valid and dbg_complete ports exposing internal state.
module rob_ss #(
    parameter  int unsigned NUM_ROB   = 32,
    parameter  int unsigned WAY       = 2,
    parameter  int unsigned CDB_PORTS = 2,
    parameter  int unsigned PR_W      = 6,
    parameter  int unsigned AR_W      = 5,
    localparam int unsigned IDX_W     = $clog2(NUM_ROB)
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       en,
    input  logic [WAY-1:0]             dispatch_valid,
    input  logic [WAY*PR_W-1:0]        dispatch_T,
    input  logic [WAY*PR_W-1:0]        dispatch_Told,
    input  logic [WAY*AR_W-1:0]        dispatch_dest,
    input  logic [WAY-1:0]             dispatch_halt,
    output logic                       dispatch_ready,
    output logic [WAY*IDX_W-1:0]       dispatch_idx,
    input  logic [CDB_PORTS-1:0]       complete_en,
    input  logic [CDB_PORTS*IDX_W-1:0] complete_idx,
    input  logic                       rollback_en,
    input  logic [IDX_W-1:0]           rollback_idx,
    output logic [WAY-1:0]             retire_valid,
    output logic [WAY*PR_W-1:0]        retire_T,
    output logic [WAY*PR_W-1:0]        retire_Told,
    output logic [WAY*AR_W-1:0]        retire_dest,
    output logic                       halt_out,
    output logic [IDX_W:0]             count
`ifdef ROB_SS_DEBUG_EN
    ,
    output logic [IDX_W-1:0]           dbg_head,
    output logic [IDX_W-1:0]           dbg_tail,
    output logic [NUM_ROB-1:0]         dbg_valid,
    output logic [NUM_ROB-1:0]         dbg_complete
`endif
);

    typedef enum logic [0:0] {
        RUN     = 1'b0,
        RECOVER = 1'b1
    } state_t;

    typedef struct packed {
        logic            halt;
        logic [AR_W-1:0] dest;
        logic [PR_W-1:0] told;
        logic [PR_W-1:0] t;
    } entry_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   rb_q, rb_d;
    logic [IDX_W-1:0]   head_q, head_d;
    logic [IDX_W-1:0]   tail_q, tail_d;
    logic [IDX_W:0]     count_q, count_d;
    logic [NUM_ROB-1:0] valid_q, valid_d;
    logic [NUM_ROB-1:0] complete_q, complete_d;
    entry_t             ent_q [NUM_ROB];

    logic [IDX_W-1:0]   ret_idx  [WAY];
    logic [IDX_W-1:0]   disp_idx [WAY];
    logic [IDX_W:0]     ret_cnt;
    logic [IDX_W:0]     disp_cnt;
    logic [IDX_W:0]     free_slots;
    logic [IDX_W-1:0]   age_rb;
    logic [IDX_W:0]     rb_span;
    logic               ret_hits_rb;
    logic               rb_accept;
    logic               disp_fire;
    logic               run_ok;

    assign count      = count_q;
    assign free_slots = (IDX_W+1)'(NUM_ROB) - count_q;
    assign rb_accept  = en && rollback_en && valid_q[rollback_idx];
    assign disp_fire  = en && dispatch_ready;
    assign age_rb     = rollback_idx - head_q;
    assign rb_span    = (IDX_W+1)'(age_rb) + (IDX_W+1)'(1);

    // Slot index generation for retire and dispatch, plus dispatch popcount.
    always_comb begin
        dispatch_idx = '0;
        disp_cnt     = '0;
        for (int k = 0; k < WAY; k++) begin
            ret_idx[k]  = head_q + IDX_W'(k);
            disp_idx[k] = tail_q + IDX_W'(k);
            dispatch_idx[k*IDX_W +: IDX_W] = disp_idx[k];
            if (dispatch_valid[k]) begin
                disp_cnt = disp_cnt + (IDX_W+1)'(1);
            end
        end
    end

    // In-order retire selection from registered state; a halt stops younger slots.
    always_comb begin
        retire_valid = '0;
        retire_T     = '0;
        retire_Told  = '0;
        retire_dest  = '0;
        halt_out     = 1'b0;
        ret_cnt      = '0;
        ret_hits_rb  = 1'b0;
        run_ok       = 1'b1;
        for (int k = 0; k < WAY; k++) begin
            run_ok = run_ok && valid_q[ret_idx[k]] && complete_q[ret_idx[k]];
            if (run_ok) begin
                retire_valid[k]                = 1'b1;
                retire_T[k*PR_W +: PR_W]       = ent_q[ret_idx[k]].t;
                retire_Told[k*PR_W +: PR_W]    = ent_q[ret_idx[k]].told;
                retire_dest[k*AR_W +: AR_W]    = ent_q[ret_idx[k]].dest;
                ret_cnt                        = ret_cnt + (IDX_W+1)'(1);
                if (ret_idx[k] == rb_q) begin
                    ret_hits_rb = 1'b1;
                end
                if (ent_q[ret_idx[k]].halt) begin
                    halt_out = 1'b1;
                    run_ok   = 1'b0;
                end
            end
        end
    end

    // Next buffer state: completion, dispatch, retire, then rollback flush.
    always_comb begin
        valid_d    = valid_q;
        complete_d = complete_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        if (en) begin
            for (int p = 0; p < CDB_PORTS; p++) begin
                if (complete_en[p] && valid_q[complete_idx[p*IDX_W +: IDX_W]]) begin
                    complete_d[complete_idx[p*IDX_W +: IDX_W]] = 1'b1;
                end
            end
            if (disp_fire) begin
                for (int k = 0; k < WAY; k++) begin
                    if (dispatch_valid[k]) begin
                        valid_d[disp_idx[k]]    = 1'b1;
                        complete_d[disp_idx[k]] = 1'b0;
                    end
                end
                tail_d = tail_q + IDX_W'(disp_cnt);
            end
            for (int k = 0; k < WAY; k++) begin
                if (retire_valid[k]) begin
                    valid_d[ret_idx[k]]    = 1'b0;
                    complete_d[ret_idx[k]] = 1'b0;
                end
            end
            head_d = head_q + IDX_W'(ret_cnt);
            if (rb_accept) begin
                // Anything older than or equal to the branch (by age from head) survives.
                for (int i = 0; i < NUM_ROB; i++) begin
                    if (IDX_W'(IDX_W'(i) - head_q) > age_rb) begin
                        valid_d[i]    = 1'b0;
                        complete_d[i] = 1'b0;
                    end
                end
                if (ret_cnt >= rb_span) begin
                    count_d = '0;
                    tail_d  = head_d;
                end else begin
                    count_d = rb_span - ret_cnt;
                    tail_d  = rollback_idx + IDX_W'(1);
                end
            end else begin
                count_d = count_q + (disp_fire ? disp_cnt : '0) - ret_cnt;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= RUN;
            rb_q    <= '0;
        end else begin
            state_q <= state_d;
            rb_q    <= rb_d;
        end
    end

    // FSM next state: enter RECOVER on rollback, leave when the branch retires or buffer empties.
    always_comb begin
        state_d = state_q;
        rb_d    = rb_q;
        if (en) begin
            if (rb_accept) begin
                state_d = RECOVER;
                rb_d    = rollback_idx;
            end else if (state_q == RECOVER && (ret_hits_rb || count_q == '0)) begin
                state_d = RUN;
            end
        end
    end

    // FSM output: dispatch allowed only with room for a full group and no recovery pending.
    always_comb begin
        dispatch_ready = 1'b0;
        if (state_q == RUN && free_slots >= (IDX_W+1)'(WAY) && !rollback_en) begin
            dispatch_ready = 1'b1;
        end
    end

    // Buffer pointers, flags and entry payload storage.
    always_ff @(posedge clock) begin
        if (reset) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            valid_q    <= '0;
            complete_q <= '0;
            for (int i = 0; i < NUM_ROB; i++) begin
                ent_q[i] <= '0;
            end
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            valid_q    <= valid_d;
            complete_q <= complete_d;
            if (disp_fire) begin
                for (int k = 0; k < WAY; k++) begin
                    if (dispatch_valid[k]) begin
                        ent_q[disp_idx[k]] <= '{halt: dispatch_halt[k],
                                                dest: dispatch_dest[k*AR_W +: AR_W],
                                                told: dispatch_Told[k*PR_W +: PR_W],
                                                t:    dispatch_T[k*PR_W +: PR_W]};
                    end
                end
            end
        end
    end

`ifdef ROB_SS_DEBUG_EN
    assign dbg_head     = head_q;
    assign dbg_tail     = tail_q;
    assign dbg_valid    = valid_q;
    assign dbg_complete = complete_q;
`endif

endmodule

// File: doc/rob_ss.md
ROB_SS -- requirements
Module: rob_ss

Interface
REQ-001 Parameter NUM_ROB, 32, entry count; power of two, >=4; IDX_W = log2(NUM_ROB).
REQ-002 Parameter WAY, 2, dispatch and retire width; 1..4, WAY < NUM_ROB.
REQ-003 Parameter CDB_PORTS, 2, completion ports.
REQ-004 Parameter PR_W, 6, physical register index width; AR_W, 5, architectural index width.
REQ-005 clock  in  1  single clock; all state updates on its rising edge.
REQ-006 reset  in  1  synchronous, active-high.
REQ-007 en  in  1  global enable; low means no state change.
REQ-008 dispatch_valid  in  WAY  per-slot request; valid bits are contiguous from slot 0.
REQ-009 dispatch_T / dispatch_Told  in  WAY*PR_W each  new and old physical tags.
REQ-010 dispatch_dest  in  WAY*AR_W  destination architectural register; dispatch_halt  in  WAY  halt marker.
REQ-011 dispatch_ready  out  1  all WAY slots may dispatch this cycle.
REQ-012 dispatch_idx  out  WAY*IDX_W  slot k gets ROB index (tail+k) mod NUM_ROB.
REQ-013 complete_en  in  CDB_PORTS; complete_idx  in  CDB_PORTS*IDX_W  completion writeback.
REQ-014 rollback_en  in  1; rollback_idx  in  IDX_W  mispredicted branch entry.
REQ-015 retire_valid  out  WAY  contiguous from slot 0; retire_T, retire_Told, retire_dest  out  per-slot tags of retiring entries.
REQ-016 halt_out  out  1  a halt entry retires this cycle; count  out  IDX_W+1  occupied entries.

Function
REQ-017 Circular buffer: head and tail wrap modulo NUM_ROB; occupancy is tracked by count, so a full buffer is distinguished from an empty one with head==tail.
REQ-018 dispatch_ready = (NUM_ROB - count >= WAY) && state==RUN && !rollback_en; it uses the current-cycle count with no same-cycle retire credit.
REQ-019 Dispatch fires when en && dispatch_ready.
- Every slot with its valid bit set is written at tail+k: valid=1, complete=0, with its tag fields.
- tail advances by popcount(dispatch_valid).
- Slots without their valid bit set are ignored.
REQ-020 A completion on port p sets complete for entry complete_idx[p] only if that entry is valid; duplicate indices across ports are harmless.
REQ-021 Retire slot k is asserted when all of the following hold:
- entries head..head+k are all valid and complete;
- no earlier slot this cycle retired a halt entry.
REQ-022 Retire outputs are combinational from registered state; a completion in cycle N makes its entry retirable in cycle N+1 at the earliest.
REQ-023 Retired entries are cleared at the clock edge; head advances by the retire count; next count = count + dispatched - retired.
REQ-024 halt_out is asserted for the cycle its halt entry retires; entries younger than the halt are not retired in that cycle.
REQ-025 Rollback is accepted when rollback_en && the entry at rollback_idx is valid; otherwise it is ignored.
REQ-026 On an accepted rollback:
- entries from rollback_idx+1 through tail-1 (modulo, wrap-aware) are invalidated;
- tail = rollback_idx+1;
- count is recomputed;
- the branch entry itself is kept.
REQ-027 Same-cycle precedence: a rollback kills dispatch; a rollback overrides a completion to any flushed entry; a retire of older entries proceeds normally.
REQ-028 FSM has two states:
- RUN goes to RECOVER on an accepted rollback, latching rollback_idx.
- RECOVER goes to RUN in the cycle the latched entry retires, or when count==0.
- Dispatch is blocked while in RECOVER.
REQ-029 A rollback arriving while in RECOVER is accepted per REQ-025 and overwrites the latched index.
REQ-030 With en=0, all outputs still reflect current state, but no dispatch, retire, completion, or rollback takes effect.

Reset
REQ-031 A synchronous reset clears the following:
- head=tail=0, count=0, state=RUN, latched index=0;
- every entry's valid, complete, halt and tag fields to 0.
REQ-032 After reset, outputs are retire_valid=0, halt_out=0, dispatch_ready=1, dispatch_idx slot k = k.
REQ-033 Reset overrides en and any same-cycle dispatch, completion, or rollback.

Configuration
REQ-034 With macro ROB_SS_DEBUG_EN defined, additional outputs dbg_head (IDX_W), dbg_tail (IDX_W), dbg_valid (NUM_ROB) and dbg_complete (NUM_ROB) expose internal state.
REQ-035 Without ROB_SS_DEBUG_EN, those ports do not exist and all other behaviour is identical.

Verification
REQ-036 Reset, then dispatch 2 per cycle for 16 cycles with no completions (NUM_ROB=32, WAY=2) -> count=32, dispatch_ready=0 from that cycle, head==tail==0.
REQ-037 Fill 4 entries, complete idx 1, 2, 3 -> no retire; then complete idx 0 -> next cycle retire_valid=2'b11 (idx 0,1), following cycle 2'b11 (idx 2,3), then count=0.
REQ-038 head=30, tail=6 (wrapped), rollback idx 31 -> entries 0..5 invalid, tail=0, count=2, state=RECOVER; dispatch_ready=0 until idx 31 retires.
REQ-039 Same cycle: rollback idx 3 with tail=8, dispatch of 2, completion of idx 5 -> dispatch dropped, entry 5 invalid, tail=4.
REQ-040 Entry 0 normal, entry 1 halt, entry 2 normal, all complete -> retire_valid=2'b11, halt_out=1; entry 2 not retired that cycle.
REQ-041 Reset asserted while count=10 and state=RECOVER -> next cycle count=0, state=RUN, dispatch_ready=1.
